// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scanner.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] CT_OFF  = 4'hF;

    // Active-low a..g patterns for hex digits 0..F.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg7_hex.sv
// Combinational hex to active-low seven-segment decoder.
module seg7_hex
    import seg_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG[i_hex];

endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment scanner with registered outputs.
// SEG_SCAN_GHOST_BLANK_EN stretches the dark gap between digits to BLANK_CYCLES.
module seg_scan
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [3:0] idnum,
    output logic [1:0] digit,
    output logic [6:0] seg,
    output logic [3:0] ct_n,
    output logic       frame_tick
);

`ifdef SEG_SCAN_GHOST_BLANK_EN
    localparam int unsigned CNT_MAX    = max_u(SCAN_DIV, BLANK_CYCLES);
    localparam int unsigned BLANK_LAST = BLANK_CYCLES - 1;
`else
    localparam int unsigned CNT_MAX    = SCAN_DIV;
    localparam int unsigned BLANK_LAST = 0;
`endif
    localparam int unsigned CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_LAST);

    if (SCAN_DIV < 2 || BLANK_CYCLES < 1) begin : g_bad_param
        $error("seg_scan: SCAN_DIV must be >= 2 and BLANK_CYCLES >= 1");
    end

    scan_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_digit;
    logic [6:0]       r_seg;
    logic [3:0]       r_ct_n;
    logic             r_tick;
    logic [6:0]       w_seg;

    seg7_hex u_dec (
        .i_hex (idnum),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_digit <= 2'd0;
            r_seg   <= SEG_OFF;
            r_ct_n  <= CT_OFF;
            r_tick  <= 1'b0;
        end else if (!en) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_digit <= 2'd0;
            r_seg   <= SEG_OFF;
            r_ct_n  <= CT_OFF;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_state <= BLANK;
                    r_digit <= 2'd0;
                    r_cnt   <= BLANK_LOAD;
                end
                BLANK: begin
                    // idnum has had the whole blank phase to settle on r_digit
                    if (r_cnt == '0) begin
                        r_seg   <= w_seg;
                        r_ct_n  <= ~(4'b0001 << r_digit);
                        r_cnt   <= SHOW_LOAD;
                        r_state <= SHOW;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                SHOW: begin
                    if (r_cnt == '0) begin
                        r_seg   <= SEG_OFF;
                        r_ct_n  <= CT_OFF;
                        r_digit <= r_digit + 2'd1;
                        r_tick  <= (r_digit == 2'd3);
                        r_cnt   <= BLANK_LOAD;
                        r_state <= BLANK;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign digit      = r_digit;
    assign seg        = r_seg;
    assign ct_n       = r_ct_n;
    assign frame_tick = r_tick;

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan against a timeline-arithmetic reference model.
module tb_seg_scan;

    localparam int unsigned SCAN_DIV     = 4;
    localparam int unsigned BLANK_CYCLES = 2;
`ifdef SEG_SCAN_GHOST_BLANK_EN
    localparam int unsigned B = BLANK_CYCLES;
`else
    localparam int unsigned B = 1;
`endif
    localparam int unsigned P = B + SCAN_DIV;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic [15:0] store;
    logic [3:0]  idnum;
    logic [1:0]  digit;
    logic [6:0]  seg;
    logic [3:0]  ct_n;
    logic        frame_tick;

    int n_checks = 0;
    int n_fails  = 0;

    logic [6:0] hex_ref [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Reference model: position m within the scan timeline since enable.
    bit         m_run;
    int         m;
    logic [6:0] e_seg_lit;
    logic [6:0] e_seg;
    logic [3:0] e_ct;
    logic [1:0] e_dig;
    logic       e_tick;

    assign idnum = store[{digit, 2'b00} +: 4];

    always #5 clk = ~clk;

    seg_scan #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .idnum      (idnum),
        .digit      (digit),
        .seg        (seg),
        .ct_n       (ct_n),
        .frame_tick (frame_tick)
    );

    task automatic model_dark();
        e_seg  = 7'h7F;
        e_ct   = 4'hF;
        e_dig  = 2'd0;
        e_tick = 1'b0;
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m     = 0;
        model_dark();
    endtask

    task automatic model_edge();
        int d;
        int ph;
        if (!en) m_run = 1'b0;
        else if (!m_run) begin
            m_run = 1'b1;
            m     = 0;
        end else m++;
        if (!m_run) model_dark();
        else begin
            d      = (m / P) % 4;
            ph     = m % P;
            e_dig  = 2'(d);
            e_tick = (ph == 0 && d == 0 && m > 0);
            if (ph == B) e_seg_lit = hex_ref[store[d*4 +: 4]];
            if (ph >= B) begin
                e_seg = e_seg_lit;
                e_ct  = ~(4'b0001 << d);
            end else begin
                e_seg = 7'h7F;
                e_ct  = 4'hF;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
    endtask

    function automatic string got_s();
        return $sformatf("seg=%h ct_n=%h digit=%0d tick=%b", seg, ct_n, digit, frame_tick);
    endfunction

    function automatic string exp_s();
        return $sformatf("seg=%h ct_n=%h digit=%0d tick=%b", e_seg, e_ct, e_dig, e_tick);
    endfunction

    task automatic test_reset();
        int first_lit = -1;
        en    = 1'b1;
        store = 16'h1119;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({seg, ct_n, digit} !== {7'h7F, 4'hF, 2'd0}) begin
            n_fails++;
            $display("FAIL reset_hold: got %s, want seg=7f ct_n=f digit=0", got_s());
        end
        model_reset();
        reset_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_checks++;
            if ({seg, ct_n, digit, frame_tick} !== {e_seg, e_ct, e_dig, e_tick}) begin
                n_fails++;
                $display("FAIL reset_release cyc %0d: got %s, want %s", k, got_s(), exp_s());
            end
            if (first_lit < 0 && ct_n !== 4'hF) begin
                first_lit = k;
                n_checks++;
                if ({ct_n, seg} !== {4'hE, 7'h10}) begin
                    n_fails++;
                    $display("FAIL first_digit: got ct_n=%h seg=%h, want ct_n=e seg=10",
                             ct_n, seg);
                end
            end
        end
        n_checks++;
        if (first_lit != int'(B + 1)) begin
            n_fails++;
            $display("FAIL first_lit_latency: got %0d cycles, want %0d", first_lit, B + 1);
        end
    endtask

    task automatic test_free_run();
        logic [3:0] exp_ct [4]  = '{4'hE, 4'hD, 4'hB, 4'h7};
        logic [6:0] exp_seg [4] = '{7'h10, 7'h79, 7'h79, 7'h79};
        logic [3:0] prev_ct = 4'hF;
        int lit_idx = 0;
        int lit_len = 0;
        int last_tick = -1;
        int n_ticks = 0;
        en    = 1'b1;
        store = 16'h1119;
        do_reset();
        for (int k = 1; k <= int'(8 * P + 2); k++) begin
            step();
            n_checks++;
            if ({seg, ct_n, digit, frame_tick} !== {e_seg, e_ct, e_dig, e_tick}) begin
                n_fails++;
                $display("FAIL free_run cyc %0d: got %s, want %s", k, got_s(), exp_s());
            end
            if (ct_n !== 4'hF) begin
                if (prev_ct === 4'hF) begin
                    n_checks++;
                    if ({ct_n, seg} !== {exp_ct[lit_idx % 4], exp_seg[lit_idx % 4]}) begin
                        n_fails++;
                        $display("FAIL free_run_seq %0d: got ct_n=%h seg=%h, want ct_n=%h seg=%h",
                                 lit_idx, ct_n, seg, exp_ct[lit_idx % 4], exp_seg[lit_idx % 4]);
                    end
                    lit_idx++;
                end
                lit_len++;
            end else if (prev_ct !== 4'hF) begin
                n_checks++;
                if (lit_len != int'(SCAN_DIV)) begin
                    n_fails++;
                    $display("FAIL lit_length: got %0d, want %0d", lit_len, SCAN_DIV);
                end
                lit_len = 0;
            end
            if (frame_tick === 1'b1) begin
                if (last_tick >= 0) begin
                    n_checks++;
                    if (k - last_tick != int'(4 * P)) begin
                        n_fails++;
                        $display("FAIL tick_period: got %0d, want %0d", k - last_tick, 4 * P);
                    end
                end
                last_tick = k;
                n_ticks++;
            end
            prev_ct = ct_n;
        end
        n_checks++;
        if (n_ticks != 2) begin
            n_fails++;
            $display("FAIL tick_count: got %0d, want 2", n_ticks);
        end
    endtask

    task automatic test_en_drop();
        bit found = 1'b0;
        en    = 1'b1;
        store = 16'h1119;
        do_reset();
        for (int k = 0; k < 100 && !found; k++) begin
            step();
            n_checks++;
            if ({seg, ct_n, digit, frame_tick} !== {e_seg, e_ct, e_dig, e_tick}) begin
                n_fails++;
                $display("FAIL en_drop_pre cyc %0d: got %s, want %s", k, got_s(), exp_s());
            end
            found = (ct_n === 4'hB);
        end
        n_checks++;
        if (!found) begin
            n_fails++;
            $display("FAIL en_drop_wait: got no digit-2 show, want ct_n=b within 100 cycles");
        end
        en = 1'b0;
        step();
        n_checks++;
        if ({seg, ct_n, digit, frame_tick} !== {7'h7F, 4'hF, 2'd0, 1'b0}) begin
            n_fails++;
            $display("FAIL en_drop: got %s, want seg=7f ct_n=f digit=0 tick=0", got_s());
        end
        repeat (3) step();
        en    = 1'b1;
        found = 1'b0;
        for (int k = 1; k <= int'(P) && !found; k++) begin
            step();
            n_checks++;
            if ({seg, ct_n, digit, frame_tick} !== {e_seg, e_ct, e_dig, e_tick}) begin
                n_fails++;
                $display("FAIL en_restart cyc %0d: got %s, want %s", k, got_s(), exp_s());
            end
            if (ct_n !== 4'hF) begin
                found = 1'b1;
                n_checks++;
                if (ct_n !== 4'hE || k != int'(B + 1)) begin
                    n_fails++;
                    $display("FAIL en_restart_digit: got ct_n=%h at %0d, want ct_n=e at %0d",
                             ct_n, k, B + 1);
                end
            end
        end
    endtask

    task automatic test_store_fa50();
        logic [6:0] exp_seq [4] = '{7'h40, 7'h12, 7'h08, 7'h0E};
        logic [3:0] prev_ct = 4'hF;
        int lit_idx = 0;
        en    = 1'b1;
        store = 16'hFA50;
        do_reset();
        for (int k = 1; k <= int'(8 * P); k++) begin
            step();
            n_checks++;
            if ({seg, ct_n, digit, frame_tick} !== {e_seg, e_ct, e_dig, e_tick}) begin
                n_fails++;
                $display("FAIL fa50 cyc %0d: got %s, want %s", k, got_s(), exp_s());
            end
            n_checks++;
            if ($countones(~ct_n) > 1) begin
                n_fails++;
                $display("FAIL one_hot cyc %0d: got ct_n=%h, want at most one low bit", k, ct_n);
            end
            if (ct_n !== 4'hF && prev_ct === 4'hF) begin
                n_checks++;
                if (seg !== exp_seq[lit_idx % 4]) begin
                    n_fails++;
                    $display("FAIL fa50_seq %0d: got seg=%h, want seg=%h",
                             lit_idx, seg, exp_seq[lit_idx % 4]);
                end
                lit_idx++;
            end
            prev_ct = ct_n;
        end
    endtask

    task automatic test_idnum_hold();
        bit found = 1'b0;
        en    = 1'b1;
        store = 16'h1119;
        do_reset();
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            found = (ct_n === 4'hE);
        end
        store = 16'h111F;
        for (int k = 1; k <= int'(4 * P + B + 1); k++) begin
            step();
            n_checks++;
            if ({seg, ct_n, digit, frame_tick} !== {e_seg, e_ct, e_dig, e_tick}) begin
                n_fails++;
                $display("FAIL idnum_hold cyc %0d: got %s, want %s", k, got_s(), exp_s());
            end
            if (k == int'(SCAN_DIV) - 1) begin
                n_checks++;
                if (seg !== 7'h10) begin
                    n_fails++;
                    $display("FAIL idnum_held: got seg=%h, want seg=10", seg);
                end
            end
        end
        n_checks++;
        if ({ct_n, seg} !== {4'hE, 7'h0E}) begin
            n_fails++;
            $display("FAIL idnum_next_visit: got ct_n=%h seg=%h, want ct_n=e seg=0e", ct_n, seg);
        end
    endtask

    task automatic test_random();
        en    = 1'b1;
        store = 16'($urandom);
        do_reset();
        for (int k = 1; k <= 400; k++) begin
            if ($urandom_range(7) == 0) store = 16'($urandom);
            if (!en) en = ($urandom_range(2) == 0);
            else if ($urandom_range(39) == 0) en = 1'b0;
            step();
            n_checks++;
            if ({seg, ct_n, digit, frame_tick} !== {e_seg, e_ct, e_dig, e_tick}) begin
                n_fails++;
                $display("FAIL random cyc %0d: got %s, want %s", k, got_s(), exp_s());
            end
        end
    endtask

    task automatic test_reset_mid_show();
        bit found = 1'b0;
        en    = 1'b1;
        store = 16'h1119;
        do_reset();
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            found = (ct_n !== 4'hF);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({seg, ct_n, digit, frame_tick} !== {7'h7F, 4'hF, 2'd0, 1'b0}) begin
            n_fails++;
            $display("FAIL async_reset: got %s, want seg=7f ct_n=f digit=0 tick=0", got_s());
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= int'(2 * P); k++) begin
            step();
            n_checks++;
            if ({seg, ct_n, digit, frame_tick} !== {e_seg, e_ct, e_dig, e_tick}) begin
                n_fails++;
                $display("FAIL reset_restart cyc %0d: got %s, want %s", k, got_s(), exp_s());
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        en      = 1'b0;
        store   = 16'h0;
        model_reset();
        test_reset();
        test_free_run();
        test_en_drop();
        test_store_fa50();
        test_idnum_hold();
        test_random();
        test_reset_mid_show();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
